// File: rtl/arb_pkg.sv
// Shared constants for the round-robin / fixed priority arbiter.
// Mode encodings select how the next winner is searched for.
package arb_pkg;

    localparam logic ARB_MODE_FIXED = 1'b0;
    localparam logic ARB_MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between sources, the arbiter and its consumer.
// The arbiter uses the slave view; sources plus consumer use master.
interface rr_priority_arbiter_if #(
    parameter int N = 8
);

    localparam int IDXW = $clog2(N);

    logic [N-1:0]    req;
    logic            mode;
    logic            gnt_ready;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic [N-1:0]    gnt_onehot;
    logic [IDXW-1:0] last_idx;

    modport master (
        output req,
        output mode,
        output gnt_ready,
        input  gnt_valid,
        input  gnt_idx,
        input  gnt_onehot,
        input  last_idx
    );

    modport slave (
        input  req,
        input  mode,
        input  gnt_ready,
        output gnt_valid,
        output gnt_idx,
        output gnt_onehot,
        output last_idx
    );

endinterface

// File: rtl/rr_priority_arbiter_rot_prio_enc.sv
// Rotating priority encoder: descending search from start, wrapping
// from 0 back to N-1; the first set request wins.
module rot_prio_enc #(
    parameter  int N    = 8,
    localparam int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] start,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [IDXW-1:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = IDXW'((int'(start) + N - k) % N);
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter with fixed MSB-first or round-robin policy,
// presenting its winner as a valid/ready grant held until accepted.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter  int N    = 8,
    localparam int IDXW = $clog2(N)
) (
    input logic                 clk,
    input logic                 rst,
    rr_priority_arbiter_if.slave bus
);

    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(N - 1);

    logic            load;
    logic            accept;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] start;
    logic            found;
    logic [IDXW-1:0] win;

    assign load   = !bus.gnt_valid || bus.gnt_ready;
    assign accept = bus.gnt_valid && bus.gnt_ready;

    // The grant accepted this cycle is the effective last winner, so
    // back-to-back accepts rotate without a cycle of pointer lag.
    assign ptr = accept ? bus.gnt_idx : bus.last_idx;

    always_comb begin
        start = TOP_IDX;
        if (bus.mode == ARB_MODE_RR) begin
            start = (ptr == '0) ? TOP_IDX : ptr - IDXW'(1);
        end
    end

    rot_prio_enc #(
        .N(N)
    ) u_enc (
        .req  (bus.req),
        .start(start),
        .found(found),
        .idx  (win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.gnt_valid  <= 1'b0;
            bus.gnt_idx    <= '0;
            bus.gnt_onehot <= '0;
            bus.last_idx   <= '0;
        end else begin
            if (accept) begin
                bus.last_idx <= bus.gnt_idx;
            end
            if (load) begin
                bus.gnt_valid  <= found;
                bus.gnt_idx    <= found ? win : '0;
                bus.gnt_onehot <= found ? (N'(1) << win) : '0;
            end
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter at N=8 and N=5, with expected
// grants queued as stimulus is driven and checked one cycle later.
module tb_rr_priority_arbiter;

    typedef struct {
        logic        v;
        logic [5:0]  idx;
        logic [63:0] oh;
        logic [5:0]  last;
        string       tag;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t exp_q[$];

    rr_priority_arbiter_if #(.N(8)) bus8 ();
    rr_priority_arbiter_if #(.N(5)) bus5 ();

    rr_priority_arbiter #(.N(8)) u_dut8 (
        .clk(clk),
        .rst(rst),
        .bus(bus8)
    );

    rr_priority_arbiter #(.N(5)) u_dut5 (
        .clk(clk),
        .rst(rst),
        .bus(bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, queue the expected post-edge state,
    // then pop and compare against the DUT at the next falling edge.
    task automatic cyc(input bit sel, input string tag, input logic r,
                       input logic [7:0] req, input logic mode,
                       input logic rdy, input logic ev,
                       input int eidx, input int elast);
        exp_t e;
        logic        ov;
        logic [63:0] oidx;
        logic [63:0] ooh;
        logic [63:0] olast;
        rst = r;
        if (sel == 1'b0) begin
            bus8.req       = req;
            bus8.mode      = mode;
            bus8.gnt_ready = rdy;
            bus5.req       = '0;
            bus5.mode      = 1'b0;
            bus5.gnt_ready = 1'b1;
        end else begin
            bus5.req       = req[4:0];
            bus5.mode      = mode;
            bus5.gnt_ready = rdy;
            bus8.req       = '0;
            bus8.mode      = 1'b0;
            bus8.gnt_ready = 1'b1;
        end
        e.v    = ev;
        e.idx  = 6'(eidx);
        e.oh   = ev ? (64'd1 << eidx) : 64'd0;
        e.last = 6'(elast);
        e.tag  = tag;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        if (sel == 1'b0) begin
            ov    = bus8.gnt_valid;
            oidx  = 64'(bus8.gnt_idx);
            ooh   = 64'(bus8.gnt_onehot);
            olast = 64'(bus8.last_idx);
        end else begin
            ov    = bus5.gnt_valid;
            oidx  = 64'(bus5.gnt_idx);
            ooh   = 64'(bus5.gnt_onehot);
            olast = 64'(bus5.last_idx);
        end
        check_bit({e.tag, ".valid"}, 64'(ov), 64'(e.v));
        check_bit({e.tag, ".idx"}, oidx, 64'(e.idx));
        check_bit({e.tag, ".onehot"}, ooh, e.oh);
        check_bit({e.tag, ".last"}, olast, 64'(e.last));
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // reset with every request asserted
        cyc(0, "rst0", 1, 8'hFF, 0, 1, 0, 0, 0);
        cyc(0, "rst1", 1, 8'hFF, 0, 1, 0, 0, 0);
        cyc(0, "rst_rel", 0, 8'hFF, 0, 1, 1, 7, 0);

        // fixed priority, held request
        cyc(0, "fix0", 0, 8'b0010_1100, 0, 1, 1, 5, 7);
        cyc(0, "fix1", 0, 8'b0010_1100, 0, 1, 1, 5, 5);
        cyc(0, "fix2", 0, 8'b0010_1100, 0, 1, 1, 5, 5);

        // round-robin rotation from a fresh pointer
        cyc(0, "rr_rst", 1, 8'h00, 1, 1, 0, 0, 0);
        cyc(0, "rr0", 0, 8'b1000_0101, 1, 1, 1, 7, 0);
        cyc(0, "rr1", 0, 8'b1000_0101, 1, 1, 1, 2, 7);
        cyc(0, "rr2", 0, 8'b1000_0101, 1, 1, 1, 0, 2);
        cyc(0, "rr3", 0, 8'b1000_0101, 1, 1, 1, 7, 0);
        cyc(0, "rr4", 0, 8'b1000_0101, 1, 1, 1, 2, 7);

        // hold while consumer stalls, even after request changes
        cyc(0, "hold_set", 0, 8'h40, 0, 1, 1, 6, 2);
        cyc(0, "hold0", 0, 8'h01, 0, 0, 1, 6, 2);
        cyc(0, "hold1", 0, 8'h01, 1, 0, 1, 6, 2);
        cyc(0, "hold2", 0, 8'h01, 0, 0, 1, 6, 2);
        cyc(0, "hold3", 0, 8'h01, 0, 0, 1, 6, 2);
        cyc(0, "hold_rel", 0, 8'h01, 0, 1, 1, 0, 6);

        // empty request drops valid, then a lone request
        cyc(0, "empty", 0, 8'h00, 0, 1, 0, 0, 0);
        cyc(0, "after_empty", 0, 8'h10, 0, 1, 1, 4, 0);

        // switch from round-robin to fixed after granting 3
        cyc(0, "sw_rr3", 0, 8'h08, 1, 1, 1, 3, 4);
        cyc(0, "sw_fix0", 0, 8'b1000_1000, 0, 1, 1, 7, 3);
        cyc(0, "sw_fix1", 0, 8'b1000_1000, 0, 1, 1, 7, 7);

        // mode change during a hold, then reset during the hold
        cyc(0, "mhold", 0, 8'h08, 1, 0, 1, 7, 7);
        cyc(0, "rst_hold", 1, 8'h08, 1, 0, 0, 0, 0);

        // single requester re-granted in round-robin
        cyc(0, "single0", 0, 8'h08, 1, 1, 1, 3, 0);
        cyc(0, "single1", 0, 8'h08, 1, 1, 1, 3, 3);

        // N=5: wrap from 0 to 4 and mode switch
        cyc(1, "n5_rst", 1, 8'h00, 1, 1, 0, 0, 0);
        cyc(1, "n5_rr0", 0, 8'b1_0001, 1, 1, 1, 4, 0);
        cyc(1, "n5_rr1", 0, 8'b1_0001, 1, 1, 1, 0, 4);
        cyc(1, "n5_wrap", 0, 8'b1_0001, 1, 1, 1, 4, 0);
        cyc(1, "n5_rr3", 0, 8'b0_1000, 1, 1, 1, 3, 4);
        cyc(1, "n5_fix0", 0, 8'b1_1000, 0, 1, 1, 4, 3);
        cyc(1, "n5_fix1", 0, 8'b1_1000, 0, 1, 1, 4, 4);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0",
                     exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
